seven_seg_demux_rx: RTL and testbench

- Receive end of the two-digit multiplexed seven-segment bus produced by our display scanner.
- The scanner drives a 7-bit segment pattern and a one-cycle strobe every FREQ+1 clocks. It alternates high digit (first strobe after reset) then low digit.
- This block samples the bus, rebuilds both raw patterns and decodes them to hex nibbles. It also checks strobe timing and reports frame completion and lock.
- Used for display-path loopback and self-test.

---
 rtl/seven_seg_demux_rx.sv | 154 +++++++++++++++
 tb/tb_seven_seg_demux_rx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_demux_rx.sv
// Receive side of the two-digit multiplexed seven-segment bus: captures the
// high/low digit patterns, decodes them to nibbles and supervises strobe timing.
module seven_seg_demux_rx #(
  parameter int FREQ  = 12500,
  parameter int TOL   = 2,
  parameter int CBITS = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       strobe_in,
  output logic [6:0] seg_hi_raw,
  output logic [6:0] seg_lo_raw,
  output logic [3:0] digit_hi,
  output logic [3:0] digit_lo,
  output logic [1:0] decode_err,
  output logic       frame_valid,
  output logic       locked,
  output logic       period_err
);

  // strobe_in has no back-pressure: every cycle it is sampled high is one
  // strobe and seg_in is taken that cycle; frame_valid is a one-cycle pulse
  // with no ready, the captured data stays on the outputs until the next frame.

  localparam logic [CBITS-1:0] P_MIN   = CBITS'(FREQ + 1 - TOL);
  localparam logic [CBITS-1:0] P_MAX   = CBITS'(FREQ + 1 + TOL);
  localparam logic [CBITS-1:0] P_LIMIT = CBITS'(FREQ + TOL + 2);
  localparam logic [CBITS-1:0] C_SAT   = '1;

  typedef enum logic {WAIT_HI = 1'b0, WAIT_LO = 1'b1} phase_t;

  phase_t           r_phase;
  phase_t           w_phase_nxt;
  logic             w_capture_hi;
  logic             w_frame_done;

  logic [6:0]       r_hi_buf;
  logic [CBITS-1:0] r_cnt;
  logic [1:0]       r_good_cnt;
  logic [1:0]       w_good_nxt;
  logic             r_first;
  logic             w_in_range;
  logic             w_bad;
  logic             w_good;
  logic             w_timeout;
  logic [4:0]       w_dec_hi;
  logic [4:0]       w_dec_lo;

  // Returns {invalid, nibble}; unknown patterns decode to nibble 0.
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h3F:   r = 5'h00;
      7'h06:   r = 5'h01;
      7'h5B:   r = 5'h02;
      7'h4F:   r = 5'h03;
      7'h66:   r = 5'h04;
      7'h6D:   r = 5'h05;
      7'h7D:   r = 5'h06;
      7'h07:   r = 5'h07;
      7'h7F:   r = 5'h08;
      7'h6F:   r = 5'h09;
      7'h77:   r = 5'h0A;
      7'h7C:   r = 5'h0B;
      7'h39:   r = 5'h0C;
      7'h5E:   r = 5'h0D;
      7'h79:   r = 5'h0E;
      7'h71:   r = 5'h0F;
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_phase <= WAIT_HI;
    else     r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_capture_hi = 1'b0;
    w_frame_done = 1'b0;
    case (r_phase)
      WAIT_HI: if (strobe_in) begin
        w_capture_hi = 1'b1;
        w_phase_nxt  = WAIT_LO;
      end
      WAIT_LO: if (strobe_in) begin
        w_frame_done = 1'b1;
        w_phase_nxt  = WAIT_HI;
      end
      default: w_phase_nxt = WAIT_HI;
    endcase
  end

  // A strobe landing exactly in the timeout cycle wins over the timeout.
  always_comb begin
    w_in_range = (r_cnt >= P_MIN) && (r_cnt <= P_MAX);
    w_bad      = strobe_in && !r_first && !w_in_range;
    w_good     = strobe_in && !r_first && w_in_range;
    w_timeout  = !strobe_in && (r_cnt == P_LIMIT);
    w_good_nxt = r_good_cnt;
    if (w_bad || w_timeout)
      w_good_nxt = 2'd0;
    else if (w_good && (r_good_cnt != 2'd3))
      w_good_nxt = r_good_cnt + 2'd1;
    w_dec_hi = decode(r_hi_buf);
    w_dec_lo = decode(seg_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_buf    <= '0;
      r_cnt       <= '0;
      r_good_cnt  <= '0;
      r_first     <= 1'b1;
      seg_hi_raw  <= '0;
      seg_lo_raw  <= '0;
      digit_hi    <= '0;
      digit_lo    <= '0;
      decode_err  <= '0;
      frame_valid <= 1'b0;
      locked      <= 1'b0;
      period_err  <= 1'b0;
    end else begin
      if (strobe_in)            r_cnt <= CBITS'(1);
      else if (r_cnt != C_SAT)  r_cnt <= r_cnt + CBITS'(1);

      if (strobe_in)      r_first <= 1'b0;
      else if (w_timeout) r_first <= 1'b1;

      r_good_cnt  <= w_good_nxt;
      period_err  <= w_bad || w_timeout;
      frame_valid <= w_frame_done;

      if (w_capture_hi) r_hi_buf <= seg_in;

      if (w_frame_done) begin
        seg_hi_raw <= r_hi_buf;
        seg_lo_raw <= seg_in;
        digit_hi   <= w_dec_hi[3:0];
        digit_lo   <= w_dec_lo[3:0];
        decode_err <= {w_dec_hi[4], w_dec_lo[4]};
      end

      if (w_bad || w_timeout)
        locked <= 1'b0;
      else if (w_frame_done && (w_good_nxt >= 2'd2))
        locked <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seven_seg_demux_rx.sv
// Bench for seven_seg_demux_rx: directed and random strobe streams checked by
// a time-based reference model through expected-response queues.
module tb_seven_seg_demux_rx;

  localparam int FREQ  = 10;
  localparam int TOL   = 1;
  localparam int CBITS = 15;
  localparam int LIMIT = FREQ + TOL + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [6:0]  seg_in = '0;
  logic        strobe_in = 1'b0;
  logic [6:0]  seg_hi_raw, seg_lo_raw;
  logic [3:0]  digit_hi, digit_lo;
  logic [1:0]  decode_err;
  logic        frame_valid, locked, period_err;

  seven_seg_demux_rx #(.FREQ(FREQ), .TOL(TOL), .CBITS(CBITS)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .strobe_in(strobe_in),
    .seg_hi_raw(seg_hi_raw), .seg_lo_raw(seg_lo_raw),
    .digit_hi(digit_hi), .digit_lo(digit_lo), .decode_err(decode_err),
    .frame_valid(frame_valid), .locked(locked), .period_err(period_err)
  );

  // full-size instance fed by a behavioural scanner
  logic        b_rst = 1'b1;
  logic [6:0]  b_seg = '0;
  logic        b_strobe = 1'b0;
  logic [6:0]  b_hi_raw, b_lo_raw;
  logic [3:0]  b_digit_hi, b_digit_lo;
  logic [1:0]  b_decode_err;
  logic        b_frame_valid, b_locked, b_period_err;
  int          b_err_cnt = 0;
  int          b_frame_cnt = 0;
  logic        big_done = 1'b0;

  seven_seg_demux_rx #(.FREQ(12500), .TOL(2), .CBITS(15)) dut_big (
    .clk(clk), .rst(b_rst), .seg_in(b_seg), .strobe_in(b_strobe),
    .seg_hi_raw(b_hi_raw), .seg_lo_raw(b_lo_raw),
    .digit_hi(b_digit_hi), .digit_lo(b_digit_lo), .decode_err(b_decode_err),
    .frame_valid(b_frame_valid), .locked(b_locked), .period_err(b_period_err)
  );

  logic [31:0] edge_cnt = '0;
  always @(posedge clk) edge_cnt <= edge_cnt + 32'd1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // reference model
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  logic [31:0] exp_frame_q[$];   // {hi, lo, dhi, dlo, derr, locked}
  logic [31:0] exp_err_q[$];     // edge index of each expected period_err

  int         m_ref;             // edge from which the current interval is measured
  bit         m_first;
  int         m_good;
  bit         m_lo_phase;
  logic [6:0] m_hibuf;
  bit         m_locked;

  // driver: one clock edge, with the model updated for that edge
  task automatic step(input logic s, input logic [6:0] seg);
    int         e, age;
    logic [4:0] dh, dl;
    e   = int'(edge_cnt) + 1;
    age = e - m_ref;
    strobe_in = s;
    seg_in    = seg;
    if (s) begin
      if (!m_first) begin
        if (age >= FREQ + 1 - TOL && age <= FREQ + 1 + TOL) begin
          if (m_good < 3) m_good++;
        end else begin
          m_good = 0;
          m_locked = 0;
          exp_err_q.push_back(32'(e));
        end
      end
      m_first = 0;
      m_ref   = e;
      if (!m_lo_phase) begin
        m_hibuf    = seg;
        m_lo_phase = 1;
      end else begin
        if (m_good >= 2) m_locked = 1;
        dh = ref_dec(m_hibuf);
        dl = ref_dec(seg);
        exp_frame_q.push_back({7'b0, m_hibuf, seg, dh[3:0], dl[3:0], dh[4], dl[4], m_locked});
        m_lo_phase = 0;
      end
    end else if (age == LIMIT) begin
      exp_err_q.push_back(32'(e));
      m_good   = 0;
      m_locked = 0;
      m_first  = 1;
    end
    @(posedge clk);
    #1;
    strobe_in = 1'b0;
  endtask

  task automatic send(input int gap, input logic [6:0] seg);
    repeat (gap - 1) step(1'b0, 7'($urandom));
    step(1'b1, seg);
  endtask

  task automatic do_reset(input int n);
    int e;
    e = 0;
    rst = 1'b1;
    strobe_in = 1'b0;
    repeat (n) begin
      e = int'(edge_cnt) + 1;
      @(posedge clk);
      #1;
    end
    chk("reset seg_hi_raw", 32'(seg_hi_raw), 0);
    chk("reset seg_lo_raw", 32'(seg_lo_raw), 0);
    chk("reset digits", 32'({digit_hi, digit_lo}), 0);
    chk("reset decode_err", 32'(decode_err), 0);
    chk("reset pulses/lock", 32'({frame_valid, locked, period_err}), 0);
    m_ref      = e + 1;
    m_first    = 1;
    m_good     = 0;
    m_lo_phase = 0;
    m_locked   = 0;
    rst = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (frame_valid) begin
      if (exp_frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_valid: got unexpected pulse, expected none (edge %0d)", edge_cnt);
      end else begin
        chk("frame {hi,lo,dhi,dlo,derr,locked}",
            {7'b0, seg_hi_raw, seg_lo_raw, digit_hi, digit_lo, decode_err, locked},
            exp_frame_q.pop_front());
      end
    end
    if (period_err) begin
      if (exp_err_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL period_err: got unexpected pulse, expected none (edge %0d)", edge_cnt);
      end else begin
        chk("period_err edge", edge_cnt, exp_err_q.pop_front());
        chk("locked on period_err", 32'(locked), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (b_period_err)  b_err_cnt   <= b_err_cnt + 1;
    if (b_frame_valid) b_frame_cnt <= b_frame_cnt + 1;
  end

  // full-size scanner loopback
  initial begin
    repeat (3) @(posedge clk);
    #1 b_rst = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    for (int k = 0; k < 4; k++) begin
      b_strobe = 1'b1;
      b_seg    = (k % 2 == 1) ? 7'h6D : 7'h7D;
      @(posedge clk);
      #1;
      b_strobe = 1'b0;
      b_seg    = 7'($urandom);
      if (k < 3) repeat (12500) begin @(posedge clk); #1; end
    end
    repeat (2) begin @(posedge clk); #1; end
    chk("big digit_hi", 32'(b_digit_hi), 6);
    chk("big digit_lo", 32'(b_digit_lo), 5);
    chk("big seg raw", 32'({b_hi_raw, b_lo_raw}), 32'({7'h7D, 7'h6D}));
    chk("big locked", 32'(b_locked), 1);
    chk("big period_err count", 32'(b_err_cnt), 0);
    chk("big frame count", 32'(b_frame_cnt), 2);
    big_done = 1'b1;
  end

  // main stimulus
  initial begin
    int gap, r;
    logic [6:0] seg;
    do_reset(3);

    // basic frame, then lock on the second frame
    send(3, 7'h06);
    send(11, 7'h4F);
    chk("t1 frame_valid", 32'(frame_valid), 1);
    chk("t1 digits", 32'({digit_hi, digit_lo}), 32'h13);
    chk("t1 locked", 32'(locked), 0);
    send(11, 7'h06);
    send(11, 7'h4F);
    chk("t1 locked 2nd frame", 32'(locked), 1);

    // invalid low pattern
    send(11, 7'h06);
    send(11, 7'h00);
    chk("t2 seg_lo_raw", 32'(seg_lo_raw), 0);
    chk("t2 digits", 32'({digit_hi, digit_lo}), 32'h10);
    chk("t2 decode_err", 32'(decode_err), 1);

    // long interval, then relock
    send(13, 7'h66);
    chk("t3 period_err", 32'(period_err), 1);
    chk("t3 locked", 32'(locked), 0);
    send(11, 7'h6D);
    chk("t3 captured", 32'({seg_hi_raw, seg_lo_raw}), 32'({7'h66, 7'h6D}));
    send(11, 7'h06);
    send(11, 7'h4F);
    chk("t3 relocked", 32'(locked), 1);

    // strobes stop: single timeout, late strobe unchecked
    repeat (LIMIT) step(1'b0, 7'($urandom));
    chk("t4 timeout pulse", 32'(period_err), 1);
    chk("t4 locked", 32'(locked), 0);
    repeat (40 - LIMIT - 1) step(1'b0, 7'($urandom));
    send(1, 7'h5B);
    chk("t4 late strobe no err", 32'(period_err), 0);
    send(11, 7'h7D);
    send(11, 7'h06);
    send(11, 7'h4F);

    // reset right after a high capture
    send(11, 7'h06);
    do_reset(3);
    send(3, 7'h7F);
    send(11, 7'h71);
    chk("t5 digits", 32'({digit_hi, digit_lo}), 32'h8F);
    chk("t5 decode_err", 32'(decode_err), 0);

    // random stream
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 19);
      if (r <= 13)      gap = 11;
      else if (r == 14) gap = 10;
      else if (r == 15) gap = 12;
      else if (r == 16) gap = 9;
      else if (r == 17) gap = 13;
      else if (r == 18) gap = 20 + $urandom_range(0, 10);
      else              gap = 14;
      if ($urandom_range(0, 3) == 0) seg = 7'($urandom);
      else                           seg = seg_tab[$urandom_range(0, 15)];
      send(gap, seg);
    end

    repeat (LIMIT + 4) step(1'b0, 7'($urandom));
    chk("frame queue drained", 32'(exp_frame_q.size()), 0);
    chk("period_err queue drained", 32'(exp_err_q.size()), 0);

    for (int i = 0; i < 60000 && !big_done; i++) @(posedge clk);
    chk("big loopback finished", 32'(big_done), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
